// File: rtl/bundle_command_dispatcher_if.sv
// Host command, mapper issue and completion-response signals of the bundle command dispatcher.
// The dispatcher attaches through the slave modport; the host/mapper side uses master.
interface bundle_command_dispatcher_if #(
  parameter int HV_ADDRESS_WIDTH = 5,
  parameter int FIFO_DEPTH       = 4,
  parameter int TAG_WIDTH        = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [HV_ADDRESS_WIDTH-1:0] cmd_hva;
  logic [HV_ADDRESS_WIDTH-1:0] cmd_hvb;
  logic [HV_ADDRESS_WIDTH-1:0] cmd_hvc;
  logic [HV_ADDRESS_WIDTH-1:0] cmd_offset;
  logic                        cmd_mode;
  logic [TAG_WIDTH-1:0]        cmd_tag;

  logic                        m_valid;
  logic [HV_ADDRESS_WIDTH-1:0] m_hva;
  logic [HV_ADDRESS_WIDTH-1:0] m_hvb;
  logic [HV_ADDRESS_WIDTH-1:0] m_hvc;
  logic [HV_ADDRESS_WIDTH-1:0] m_hv_offset;
  logic                        m_mode;
  logic                        m_done;

  logic                        rsp_valid;
  logic [TAG_WIDTH-1:0]        rsp_tag;
  logic [1:0]                  rsp_status;
  logic                        busy;
  logic [CW-1:0]               fifo_count;

  modport master (
    output cmd_valid, cmd_hva, cmd_hvb, cmd_hvc, cmd_offset, cmd_mode, cmd_tag, m_done,
    input  cmd_ready, m_valid, m_hva, m_hvb, m_hvc, m_hv_offset, m_mode,
           rsp_valid, rsp_tag, rsp_status, busy, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_hva, cmd_hvb, cmd_hvc, cmd_offset, cmd_mode, cmd_tag, m_done,
    output cmd_ready, m_valid, m_hva, m_hvb, m_hvc, m_hv_offset, m_mode,
           rsp_valid, rsp_tag, rsp_status, busy, fifo_count
  );
endinterface

// File: rtl/bundle_command_dispatcher.sv
// Queues bundling commands and issues them one at a time to BundleLinearMapper
// using level valid / done, returning a tagged completion status per command.
module bundle_command_dispatcher #(
  parameter int HV_ADDRESS_WIDTH  = 5,
  parameter int FIFO_DEPTH        = 4,
  parameter int TAG_WIDTH         = 4,
  parameter int DONE_TIMEOUT_CLKS = 255
) (
  input logic clk,
  input logic reset,
  bundle_command_dispatcher_if.slave bus
);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int TMW = $clog2(DONE_TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0]  COUNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  COUNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0]  COUNT_ZERO = CW'(1'b0);
  localparam logic [PW-1:0]  PTR_ONE    = PW'(1'b1);
  localparam logic [TMW-1:0] TIMER_ONE  = TMW'(1'b1);
  localparam logic [TMW-1:0] TIMER_LAST = TMW'(DONE_TIMEOUT_CLKS - 1);
  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
  localparam logic [1:0] STATUS_ILLEGAL = 2'b10;

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_ISSUE = 2'b01, ST_RELEASE = 2'b10} state_t;

  typedef struct packed {
    logic [HV_ADDRESS_WIDTH-1:0] hva;
    logic [HV_ADDRESS_WIDTH-1:0] hvb;
    logic [HV_ADDRESS_WIDTH-1:0] hvc;
    logic [HV_ADDRESS_WIDTH-1:0] offset;
    logic                        mode;
    logic [TAG_WIDTH-1:0]        tag;
  } cmd_t;

  cmd_t                        mem_r [FIFO_DEPTH];
  cmd_t                        head_s;
  cmd_t                        wr_cmd_s;
  state_t                      state_r, state_s;
  logic [PW-1:0]               rd_ptr_r, wr_ptr_r;
  logic [CW-1:0]               count_r, count_s;
  logic [TMW-1:0]              timer_r;
  logic                        push_s, pop_s, load_s, m_valid_s, rsp_fire_s;
  logic [1:0]                  rsp_status_s;
  logic [TAG_WIDTH-1:0]        rsp_tag_s;
  logic                        cmd_ready_r, busy_r, m_valid_r, m_mode_r;
  logic [HV_ADDRESS_WIDTH-1:0] m_hva_r, m_hvb_r, m_hvc_r, m_offset_r;
  logic [TAG_WIDTH-1:0]        tag_hold_r, rsp_tag_r;
  logic                        rsp_valid_r;
  logic [1:0]                  rsp_status_r;

  assign head_s   = mem_r[rd_ptr_r];
  assign wr_cmd_s = '{hva: bus.cmd_hva, hvb: bus.cmd_hvb, hvc: bus.cmd_hvc,
                      offset: bus.cmd_offset, mode: bus.cmd_mode, tag: bus.cmd_tag};

  // Issue FSM: pop/legality check in IDLE, done/timeout watch in ISSUE, done-low wait in RELEASE.
  always_comb begin
    state_s      = state_r;
    pop_s        = 1'b0;
    load_s       = 1'b0;
    m_valid_s    = 1'b0;
    rsp_fire_s   = 1'b0;
    rsp_status_s = rsp_status_r;
    rsp_tag_s    = rsp_tag_r;
    case (state_r)
      ST_IDLE: begin
        if (count_r != COUNT_ZERO) begin
          pop_s = 1'b1;
          if (head_s.hvb >= head_s.hva) begin
            load_s    = 1'b1;
            m_valid_s = 1'b1;
            state_s   = ST_ISSUE;
          end else begin
            rsp_fire_s   = 1'b1;
            rsp_status_s = STATUS_ILLEGAL;
            rsp_tag_s    = head_s.tag;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // done takes priority over a timeout expiring in the same cycle
        if (bus.m_done) begin
          rsp_fire_s   = 1'b1;
          rsp_status_s = STATUS_OK;
          rsp_tag_s    = tag_hold_r;
          state_s      = ST_RELEASE;
        end else if (timer_r == TIMER_LAST) begin
          rsp_fire_s   = 1'b1;
          rsp_status_s = STATUS_TIMEOUT;
          rsp_tag_s    = tag_hold_r;
          state_s      = ST_RELEASE;
        end else begin
          m_valid_s = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (bus.m_done) begin
          state_s = ST_RELEASE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Queue occupancy after this cycle's push and pop.
  always_comb begin
    push_s = bus.cmd_valid & cmd_ready_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + COUNT_ONE;
      2'b01:   count_s = count_r - COUNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // Queue storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= wr_cmd_s;
    end
  end

  // Control state, pointers, timeout counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      count_r      <= '0;
      timer_r      <= '0;
      cmd_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      m_valid_r    <= 1'b0;
      m_hva_r      <= '0;
      m_hvb_r      <= '0;
      m_hvc_r      <= '0;
      m_offset_r   <= '0;
      m_mode_r     <= 1'b0;
      tag_hold_r   <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_tag_r    <= '0;
      rsp_status_r <= 2'b00;
    end else begin
      state_r      <= state_s;
      count_r      <= count_s;
      cmd_ready_r  <= (count_s != COUNT_FULL);
      busy_r       <= (state_s != ST_IDLE) || (count_s != COUNT_ZERO);
      m_valid_r    <= m_valid_s;
      rsp_valid_r  <= rsp_fire_s;
      rsp_tag_r    <= rsp_tag_s;
      rsp_status_r <= rsp_status_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (load_s) begin
        m_hva_r    <= head_s.hva;
        m_hvb_r    <= head_s.hvb;
        m_hvc_r    <= head_s.hvc;
        m_offset_r <= head_s.offset;
        m_mode_r   <= head_s.mode;
        tag_hold_r <= head_s.tag;
      end
      if ((state_r == ST_ISSUE) && (state_s == ST_ISSUE)) begin
        timer_r <= timer_r + TIMER_ONE;
      end else begin
        timer_r <= '0;
      end
    end
  end

  assign bus.cmd_ready   = cmd_ready_r;
  assign bus.busy        = busy_r;
  assign bus.fifo_count  = count_r;
  assign bus.m_valid     = m_valid_r;
  assign bus.m_hva       = m_hva_r;
  assign bus.m_hvb       = m_hvb_r;
  assign bus.m_hvc       = m_hvc_r;
  assign bus.m_hv_offset = m_offset_r;
  assign bus.m_mode      = m_mode_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_tag     = rsp_tag_r;
  assign bus.rsp_status  = rsp_status_r;
endmodule

// File: doc/bundle_command_dispatcher.md
Name: bundle_command_dispatcher

Overview:
- Upstream command stage for BundleLinearMapper: queues bundling commands (hva, hvb, hvc, hv_offset, mode) in a small FIFO.
- Issues commands one at a time using the mapper's level-valid/done protocol: valid is held until done, then released.
- Reports per-command completion status with a tag to the host/controller side.

Parameters:
HV_ADDRESS_WIDTH, 5, width of hypervector address fields
FIFO_DEPTH, 4, command queue entries (power of two, >=2)
TAG_WIDTH, 4, host command tag width
DONE_TIMEOUT_CLKS, 255, max cycles m_valid is held waiting for m_done

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  host command present
cmd_ready  out  1  queue can accept (= not full)
cmd_hva  in  HV_ADDRESS_WIDTH  first input hypervector base
cmd_hvb  in  HV_ADDRESS_WIDTH  last input hypervector base
cmd_hvc  in  HV_ADDRESS_WIDTH  result hypervector base
cmd_offset  in  HV_ADDRESS_WIDTH  element offset
cmd_mode  in  1  bundling mode
cmd_tag  in  TAG_WIDTH  host tag, echoed on response
m_valid  out  1  command valid to mapper
m_hva/m_hvb/m_hvc/m_hv_offset  out  HV_ADDRESS_WIDTH each  issued fields
m_mode  out  1  issued mode
m_done  in  1  mapper completion
rsp_valid  out  1  one-cycle completion pulse
rsp_tag  out  TAG_WIDTH  tag of completed command
rsp_status  out  2  00 OK, 01 TIMEOUT, 10 ILLEGAL
busy  out  1  FSM not IDLE or queue non-empty
fifo_count  out  clog2(FIFO_DEPTH)+1  queued entries

Behaviour:
- Reset (async, immediate): all outputs 0 except cmd_ready=1; FIFO emptied, timeout counter 0, FSM=IDLE. Reset mid-ISSUE drops m_valid immediately; the in-flight command is discarded with no response.
- All outputs registered. cmd_ready = (fifo_count != FIFO_DEPTH). A push occurs on cmd_valid & cmd_ready.
- Push and pop in the same cycle leave fifo_count unchanged. A push while full cannot occur. Pop only when non-empty.
- An entry pushed in cycle N is poppable in N+1.
- FSM IDLE: if FIFO non-empty, pop into holding regs.
  - Legal command (hvb >= hva): next state ISSUE; m_valid=1 and m_* fields valid from the next cycle.
  - Illegal command (hvb < hva): no issue; rsp_valid=1, status 10, tag next cycle; remain IDLE. A further pop is allowed the following cycle.
- FSM ISSUE:
  - m_valid=1; m_* fields held stable.
  - Timeout counter increments each cycle.
  - If m_done=1: m_valid=0 next cycle, rsp pulse (status 00), go RELEASE.
  - Else if counter == DONE_TIMEOUT_CLKS-1: m_valid=0 next cycle, rsp pulse (status 01), go RELEASE.
  - If m_done and timeout coincide, m_done wins (status 00).
- FSM RELEASE:
  - m_valid=0; counter cleared.
  - Stay while m_done=1; go IDLE when m_done=0. Minimum one cycle in RELEASE.
  - Prevents re-issue while the mapper still reports the previous done.
- Latency, empty queue: push at cycle 0 -> m_valid high at cycle 2. Done sampled at cycle D -> m_valid low and rsp_valid at D+1.
- rsp_valid is exactly one cycle wide; rsp_tag/rsp_status are held until the next response.
- m_done seen outside ISSUE is ignored, except for the RELEASE wait.

Test Plan:
- Single cmd: push at cycle 0 {hva=0, hvb=8, hvc=12, offset=0, mode=1, tag=3}; m_done=1 at cycle 10 for 1 cycle -> m_valid=1 with those fields at cycles 2-10, 0 at 11; rsp_valid=1, tag=3, status=00 at cycle 11; busy=0 by cycle 13.
- Queue fill: m_done held 0, push 6 cmds back-to-back -> 5 accepted (first popped at cycle 1), cmd_ready=0 with fifo_count=4. Pulse m_done -> 6th accepted, commands issue in push order, tags returned in order.
- Illegal: push {hva=8, hvb=4, tag=9} -> m_valid never rises; rsp_valid, status=10, tag=9 at cycle 2; a following legal cmd issues at cycle 3 or later.
- Timeout: DONE_TIMEOUT_CLKS=16, m_done never asserted -> m_valid high 16 cycles then low; rsp status=01. A following queued cmd issues normally.
- Sticky done: m_done held 1 for 4 cycles after completion, second cmd queued -> second m_valid rises only after m_done returns 0.
- Reset mid-ISSUE with 2 queued -> m_valid, rsp_valid, fifo_count=0 immediately; no response for discarded commands; cmd_ready=1.
